phreg_release_queue: RTL and testbench
======================================

// Module: phreg_release_queue
// PURPOSE
//  Commit-side producer for the rename free list: collects the old physical destination registers of up to
//  two committing instructions per cycle, buffers them, and returns up to two per cycle to the free list
//  (add_free_register/free_register). Holds releases while the free list is rolling back, because writes are dropped then.
//  Sits between the commit stage (graduation list) and the free list in the rename stage.
// PARAMETERS
//  DEPTH      8   pending-release entries; power of two, >= 4
//  CNT_W      $clog2(DEPTH)+1   occupancy counter width (derived localparam, not overridable)
// PORTS
//  clk_i                 in   1        clock
//  rst_i                 in   1        asynchronous reset, active-high
//  commit_valid_i        in   2        per-lane commit of an instruction that wrote a register
//  commit_old_phreg_i    in   2xphreg_t old physical register of each committing lane
//  hold_i                in   1        free list busy (driven by commit_roll_back); no dequeue this cycle
//  ready_o               out  1        >=2 free entries; commit may present two lanes next edge
//  add_free_register_o   out  2        per-lane release strobe to free list
//  free_register_o       out  2xphreg_t released register per lane
//  num_pending_o         out  CNT_W    current occupancy
//  overflow_o            out  1        sticky: enqueue attempted with ready_o low
// BEHAVIOUR
//  - Reset (async, rst_i=1): head=tail=0, count=0, overflow_o=0, ready_o=1, add_free_register_o=0,
//    free_register_o=0, num_pending_o=0. Table contents need no reset.
//  - Enqueue filter: lane k accepted iff commit_valid_i[k] & commit_old_phreg_i[k]!=0 & ready_o.
//    phreg 0 is never released. Accepted lanes compacted in lane order: lane0 at tail, lane1 at tail (if lane0
//    not accepted) or tail+1. enq in {0,1,2}.
//  - Commit with a valid non-zero lane while ready_o=0: entries dropped, overflow_o set, stays 1 until reset.
//  - Dequeue: deq = hold_i ? 0 : min(count,2), count = registered occupancy before this cycle's enqueue.
//    Outputs combinational from head: lane0 = table[head] when deq>=1, lane1 = table[head+1] when deq==2.
//    Unused output lanes drive add=0, free_register=0. Lane0 always holds the older entry.
//  - Latency: a register committed at edge N appears on outputs in cycle N+1 earliest (no bypass).
//  - Update at edge: tail+=enq, head+=deq (mod DEPTH, natural wrap), count<=count+enq-deq.
//    Simultaneous enqueue/dequeue legal in the same cycle, including with wrap of either pointer.
//  - ready_o = (DEPTH - count) >= 2, from registered count only (no combinational path from commit_valid_i).
//  - hold_i: outputs forced idle, head/count unchanged except enqueues; pending entries preserved, never flushed
//    (they belong to committed instructions). Resume on first cycle hold_i=0.
//  - Order preserved: registers leave in commit order, lane0-before-lane1 within a cycle.
//  - Reset mid-operation clears all pending entries; outputs idle in the same cycle reset asserts.
//  - Invariant: 0<=count<=DEPTH; count==DEPTH implies ready_o=0.
// STRUCTURE
//  - drac_pkg: phreg_t (existing), new localparam RELEASE_QUEUE_DEPTH=8, typedef release_ptr_t.
//  - Single module; the table + pointers are a 2-write/2-read circular buffer, small enough to stay inline.
//    No sub-module.
// TESTING
//  1 Reset: rst_i=1 mid-traffic with count=5 -> outputs idle same cycle, num_pending_o=0, ready_o=1 after release.
//  2 Commit lanes {33,40} at edge 0, hold_i=0 -> cycle 1: add=2'b11, free={lane0=33,lane1=40}, count 2->0.
//  3 Commit lane0 phreg 0, lane1 phreg 45 -> only 45 enqueued, appears on lane0 next cycle, lane1 idle.
//  4 hold_i=1 for 4 cycles while committing 2/cycle -> count 0,2,4,6,8; ready_o=0 at 8; then hold_i=0 -> 2 released/cycle in order.
//  5 Full queue (count=8), commit valid lane {50} -> dropped, overflow_o=1 and sticky; queue contents unchanged.
//  6 Wrap: head=tail=7, commit {34,35} then {36,37} -> outputs 34,35 then 36,37; pointers wrap to 1; no loss/dup.

Source files
------------

// File: rtl/drac_pkg.sv
// Shared rename-stage types: physical register tag and release queue sizing.
package drac_pkg;

    localparam int PHREG_W = 6;
    typedef logic [PHREG_W-1:0] phreg_t;

    localparam int RELEASE_QUEUE_DEPTH = 8;
    typedef logic [$clog2(RELEASE_QUEUE_DEPTH)-1:0] release_ptr_t;

endpackage

// File: rtl/phreg_release_queue.sv
// Release queue between commit and the rename free list. Old destination
// registers of up to two committing instructions are buffered in a small
// 2-write/2-read circular buffer. Up to two are returned per cycle. Returns
// are held while the free list rolls back, because it drops writes then.
module phreg_release_queue
    import drac_pkg::*;
#(
    parameter int  DEPTH = RELEASE_QUEUE_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       commit_valid_i,
    input  phreg_t [1:0]     commit_old_phreg_i,
    input  logic             hold_i,
    output logic             ready_o,
    output logic [1:0]       add_free_register_o,
    output phreg_t [1:0]     free_register_o,
    output logic [CNT_W-1:0] num_pending_o,
    output logic             overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);

    phreg_t           entries_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic [1:0]       lane_ok;
    logic [1:0]       accept;
    logic [1:0]       enq;
    logic [1:0]       deq;
    logic [PTR_W-1:0] wr_idx1;

    // Room for a full two-lane commit, decided from registered occupancy only
    always_comb ready_o = (count_q <= CNT_W'(DEPTH - 2));

    // Enqueue filter: phreg 0 is never released; lane1 compacts onto lane0's slot if lane0 is empty
    always_comb begin
        lane_ok[0] = commit_valid_i[0] && (commit_old_phreg_i[0] != '0);
        lane_ok[1] = commit_valid_i[1] && (commit_old_phreg_i[1] != '0);
        accept     = lane_ok & {2{ready_o}};
        enq        = {1'b0, accept[0]} + {1'b0, accept[1]};
        wr_idx1    = accept[0] ? tail_q + PTR_W'(1) : tail_q;
    end

    // Dequeue count from pre-enqueue occupancy, so a new entry never bypasses to the outputs
    always_comb begin
        deq = 2'd0;
        if (!hold_i)
            deq = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];
    end

    // Release outputs read straight from the head; lane0 carries the older entry
    always_comb begin
        add_free_register_o = 2'b00;
        free_register_o     = '0;
        if (deq != 2'd0) begin
            add_free_register_o[0] = 1'b1;
            free_register_o[0]     = entries_q[head_q];
        end
        if (deq == 2'd2) begin
            add_free_register_o[1] = 1'b1;
            free_register_o[1]     = entries_q[head_q + PTR_W'(1)];
        end
    end

    // Table storage needs no reset; only pointers decide what is valid
    always_ff @(posedge clk_i) begin
        if (accept[0]) entries_q[tail_q]  <= commit_old_phreg_i[0];
        if (accept[1]) entries_q[wr_idx1] <= commit_old_phreg_i[1];
    end

    // Pointer, occupancy and sticky overflow update
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_o <= 1'b0;
        end else begin
            tail_q  <= tail_q + PTR_W'(enq);
            head_q  <= head_q + PTR_W'(deq);
            count_q <= count_q + CNT_W'(enq) - CNT_W'(deq);
            if ((|lane_ok) && !ready_o)
                overflow_o <= 1'b1;
        end
    end

    assign num_pending_o = count_q;

endmodule

// File: tb/tb_phreg_release_queue.sv
// Bench for phreg_release_queue: directed scenarios then random traffic,
// all checked against a queue-based model of the release behaviour.
module tb_phreg_release_queue;
    import drac_pkg::*;

    localparam int DEPTH = RELEASE_QUEUE_DEPTH;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       commit_valid = '0;
    phreg_t [1:0]     commit_old = '0;
    logic             hold = 1'b0;
    logic             ready;
    logic [1:0]       add_free;
    phreg_t [1:0]     free_reg;
    logic [CNT_W-1:0] num_pending;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending registers in commit order, plus the sticky flag
    int mq[$];
    bit m_ovf;

    phreg_release_queue #(.DEPTH(DEPTH)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .commit_valid_i      (commit_valid),
        .commit_old_phreg_i  (commit_old),
        .hold_i              (hold),
        .ready_o             (ready),
        .add_free_register_o (add_free),
        .free_register_o     (free_reg),
        .num_pending_o       (num_pending),
        .overflow_o          (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Called just after a rising edge; reset asserts mid-cycle and outputs must idle at once
    task automatic do_reset();
        rst          = 1'b1;
        commit_valid = '0;
        hold         = 1'b0;
        #1;
        chk("rst_add", add_free, 0);
        chk("rst_free0", free_reg[0], 0);
        chk("rst_free1", free_reg[1], 0);
        chk("rst_pending", num_pending, 0);
        chk("rst_ready", ready, 1);
        chk("rst_ovf", overflow, 0);
        mq.delete();
        m_ovf = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive inputs, check outputs at the falling edge, advance the model at the rising edge
    task automatic step(input logic [1:0] v, input int p0, input int p1, input logic h);
        int n_out;
        bit rdy;
        int p[2];
        p[0] = p0;
        p[1] = p1;
        commit_valid  = v;
        commit_old[0] = phreg_t'(p0);
        commit_old[1] = phreg_t'(p1);
        hold          = h;
        @(negedge clk);
        rdy   = (DEPTH - mq.size()) >= 2;
        n_out = h ? 0 : (mq.size() < 2 ? mq.size() : 2);
        chk("ready", ready, rdy);
        chk("pending", num_pending, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("add", add_free, n_out == 2 ? 3 : n_out);
        chk("free0", free_reg[0], n_out >= 1 ? mq[0] : 0);
        chk("free1", free_reg[1], n_out == 2 ? mq[1] : 0);
        @(posedge clk);
        repeat (n_out) void'(mq.pop_front());
        for (int k = 0; k < 2; k++) begin
            if (v[k] && p[k] != 0) begin
                if (rdy) mq.push_back(p[k]);
                else     m_ovf = 1;
            end
        end
        #1;
    endtask

    initial begin
        #1;
        do_reset();

        // Two lanes committed, both return next cycle in lane order
        step(2'b11, 33, 40, 1'b0);
        step(2'b00, 0, 0, 1'b0);
        step(2'b00, 0, 0, 1'b0);

        // phreg 0 filtered, lane1's register compacts to the head
        step(2'b11, 0, 45, 1'b0);
        step(2'b00, 0, 0, 1'b0);
        step(2'b00, 0, 0, 1'b0);

        // Hold while committing two per cycle until full
        for (int i = 0; i < 4; i++) step(2'b11, 2 * i + 1, 2 * i + 2, 1'b1);
        chk("full_ready", ready, 0);
        chk("full_count", num_pending, DEPTH);

        // Commit into a full queue: dropped, overflow sticks
        step(2'b01, 50, 0, 1'b1);
        step(2'b00, 0, 0, 1'b1);
        chk("ovf_sticky", overflow, 1);

        // Release resumes in order, two per cycle
        for (int i = 0; i < 5; i++) step(2'b00, 0, 0, 1'b0);
        chk("ovf_after_drain", overflow, 1);

        // Reset in the middle of traffic with five pending
        step(2'b11, 11, 12, 1'b1);
        step(2'b11, 13, 14, 1'b1);
        step(2'b01, 15, 0, 1'b1);
        chk("pre_rst_count", num_pending, 5);
        do_reset();

        // Walk both pointers to 7, then two pairs that straddle the wrap
        for (int i = 0; i < 7; i++) step(2'b01, 20 + i, 0, 1'b0);
        step(2'b00, 0, 0, 1'b0);
        step(2'b11, 34, 35, 1'b0);
        step(2'b11, 36, 37, 1'b0);
        step(2'b00, 0, 0, 1'b0);
        step(2'b00, 0, 0, 1'b0);

        // Random traffic in phases of differing hold pressure
        for (int c = 0; c < 600; c++) begin
            int hold_pct;
            logic [1:0] v;
            int p0;
            int p1;
            hold_pct = ((c / 40) % 3 == 0) ? 0 : ((c / 40) % 3 == 1) ? 30 : 75;
            v  = 2'($urandom_range(0, 3));
            p0 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
            p1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
            step(v, p0, p1, int'($urandom_range(0, 99)) < hold_pct);
            if (c == 300) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
